// File: rtl/axi4_write_arbiter.sv
// axi4_write_arbiter: round-robin share of the single-beat axi4_master write port.
// Ports: REQ_*/RSP_* requester side, WRITE_* master side, BUSY/GRANT_ID/TIMEOUT status; `AXI4_WR_ARB_TIMEOUT_EN adds a watchdog.
module axi4_write_arbiter #(
  parameter int P_NUM_REQ        = 4,
  parameter int P_ADDR_WIDTH     = 32,
  parameter int P_DATA_WIDTH     = 32,
  parameter int P_TIMEOUT_CYCLES = 1024
) (
  input  logic                              CLOCK,
  input  logic                              RESET,
  input  logic [P_NUM_REQ-1:0]              REQ_VALID,
  input  logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] REQ_DATA,
  output logic [P_NUM_REQ-1:0]              REQ_READY,
  output logic [P_NUM_REQ-1:0]              RSP_DONE,
  output logic [P_NUM_REQ-1:0]              RSP_ERROR,
  output logic                              WRITE_START,
  output logic [P_ADDR_WIDTH-1:0]           WRITE_ADDR,
  output logic [P_DATA_WIDTH-1:0]           WRITE_DATA,
  input  logic                              WRITE_READY,
  input  logic                              WRITE_DONE,
  input  logic                              WRITE_ERROR,
  output logic                              BUSY,
  output logic [$clog2(P_NUM_REQ)-1:0]      GRANT_ID,
  output logic                              TIMEOUT
);

  localparam int IW = $clog2(P_NUM_REQ);

  // bit1 = busy, bit0 = command valid, so both outputs come straight off flops
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b11,
    S_WAIT  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]           rr;
  logic [IW-1:0]           win;
  logic [IW-1:0]           cand;
  logic [IW-1:0]           grant_q;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic [P_NUM_REQ-1:0]    done_q;
  logic [P_NUM_REQ-1:0]    err_q;
  logic                    accept;
  logic                    fin;
  logic                    fin_err;
  logic                    expire_hit;

  // descending scan so the candidate closest to rr is written last
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((32'(rr) + 32'(k)) % P_NUM_REQ);
      if (REQ_VALID[cand]) win = cand;
    end
  end

  assign accept = (state == S_IDLE) && WRITE_READY && (|REQ_VALID);

  always_comb begin
    REQ_READY = '0;
    if (accept) REQ_READY[win] = 1'b1;
  end

`ifdef AXI4_WR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          tmo_q;

  // a completion arriving on the expiry edge wins over the watchdog
  assign expire_hit = (state != S_IDLE)
                   && (cnt == CW'(P_TIMEOUT_CYCLES - 1))
                   && !((state == S_WAIT) && WRITE_DONE);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (accept)                cnt <= '0;
      else if (state != S_IDLE)  cnt <= cnt + 1'b1;
      if (expire_hit)            tmo_q <= 1'b1;
    end
  end

  assign TIMEOUT = tmo_q;
`else
  assign expire_hit = 1'b0;
  assign TIMEOUT    = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    fin_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (expire_hit) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end else if (WRITE_READY) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (WRITE_DONE) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
          fin_err   = WRITE_ERROR;
        end else if (expire_hit) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rr      <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      if (accept) begin
        grant_q <= win;
        addr_q  <= REQ_ADDR[int'(win)*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        data_q  <= REQ_DATA[int'(win)*P_DATA_WIDTH +: P_DATA_WIDTH];
      end
      if (fin) begin
        done_q[grant_q] <= 1'b1;
        err_q[grant_q]  <= fin_err;
        rr <= (grant_q == IW'(P_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign WRITE_START = state[0];
  assign BUSY        = state[1];
  assign WRITE_ADDR  = addr_q;
  assign WRITE_DATA  = data_q;
  assign GRANT_ID    = grant_q;
  assign RSP_DONE    = done_q;
  assign RSP_ERROR   = err_q;

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// tb_axi4_write_arbiter: vector table, hand sequences and randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_axi4_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_done;
  logic [N-1:0]    rsp_error;
  logic            write_start;
  logic [AW-1:0]   write_addr;
  logic [DW-1:0]   write_data;
  logic            write_ready;
  logic            write_done;
  logic            write_error;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout;

  axi4_write_arbiter #(
    .P_NUM_REQ(N), .P_ADDR_WIDTH(AW),
    .P_DATA_WIDTH(DW), .P_TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK(clk), .RESET(rst_n),
    .REQ_VALID(req_valid), .REQ_ADDR(req_addr),
    .REQ_DATA(req_data), .REQ_READY(req_ready),
    .RSP_DONE(rsp_done), .RSP_ERROR(rsp_error),
    .WRITE_START(write_start), .WRITE_ADDR(write_addr),
    .WRITE_DATA(write_data), .WRITE_READY(write_ready),
    .WRITE_DONE(write_done), .WRITE_ERROR(write_error),
    .BUSY(busy), .GRANT_ID(grant_id), .TIMEOUT(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    return N'(1) << g;
  endfunction

  // first valid requester at or after rr, wrapping
  function automatic int pick(input logic [N-1:0] v, input int rr);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = v >> ((rr + k) % N);
      if (t[0]) return (rr + k) % N;
    end
    return -1;
  endfunction

  logic [N-1:0]  pend_v;
  logic [AW-1:0] pend_addr [N];
  logic [DW-1:0] pend_data [N];

  task automatic pack();
    req_valid = pend_v;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = pend_addr[i];
      req_data[i*DW +: DW] = pend_data[i];
    end
  endtask

  // transaction-level model state
  int            rr_m;
  bit            busy_m, sent_m, acc_m, m_out;
  int            g_m, m_dly, stall;
  logic [AW-1:0] ga_m;
  logic [DW-1:0] gd_m;
  logic [N-1:0]  owned;
  bit            ready_prev, done_prev, err_prev;
  int            grants[$];

  task automatic model_clear();
    rr_m = 0; busy_m = 0; sent_m = 0; acc_m = 0; m_out = 0;
    g_m = 0; m_dly = 0; stall = 0; owned = '0; pend_v = '0;
    ready_prev = 0; done_prev = 0; err_prev = 0;
    for (int i = 0; i < N; i++) begin
      pend_addr[i] = '0;
      pend_data[i] = '0;
    end
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    write_ready = 0; write_done = 0; write_error = 0;
    model_clear();
    pack();
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]  mask;
    logic          err;
    int            rdly;
    int            ddly;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            g;
  } vec_t;

  vec_t tbl [8];

  task automatic txn(input vec_t v, input string tag);
    logic [N-1:0] eerr;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      pend_addr[i] = $urandom;
      pend_data[i] = $urandom;
    end
    pend_addr[v.g] = v.addr;
    pend_data[v.g] = v.data;
    pend_v = v.mask;
    write_ready = 1;
    pack();
    #1;
    chk({tag, "_req_ready"}, req_ready, onehot(v.g));
    @(negedge clk);
    pend_v = '0;
    pack();
    write_ready = (v.rdly == 0);
    chk({tag, "_start"}, write_start, 1);
    chk({tag, "_addr"}, write_addr, v.addr);
    chk({tag, "_data"}, write_data, v.data);
    chk({tag, "_grant"}, grant_id, v.g);
    chk({tag, "_busy"}, busy, 1);
    for (int c = 0; c < v.rdly; c++) begin
      @(negedge clk);
      if (c == v.rdly - 1) write_ready = 1;
      chk({tag, "_start_hold"}, write_start, 1);
      chk({tag, "_addr_hold"}, {write_addr, write_data},
          {v.addr, v.data});
    end
    @(negedge clk);
    write_ready = 0;
    chk({tag, "_start_drop"}, write_start, 0);
    for (int c = 0; c < v.ddly; c++) begin
      @(negedge clk);
      chk({tag, "_no_done"}, rsp_done, 0);
    end
    write_done = 1;
    write_error = v.err;
    @(negedge clk);
    write_done = 0;
    write_error = 0;
    eerr = v.err ? onehot(v.g) : '0;
    chk({tag, "_rsp_done"}, rsp_done, onehot(v.g));
    chk({tag, "_rsp_error"}, rsp_error, eerr);
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, rsp_done, 0);
  endtask

  task automatic run_env(input int ncyc, input bit all_mode);
    logic [N-1:0] ev;
    logic [N-1:0] eerr;
    int           w;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (acc_m) begin
        busy_m = 1; sent_m = 0; stall = 0;
        owned  = owned | onehot(g_m);
        pend_v = pend_v & ~onehot(g_m);
        grants.push_back(g_m);
        chk("env_start", write_start, 1);
        chk("env_addr", write_addr, ga_m);
        chk("env_data", write_data, gd_m);
        chk("env_grant", grant_id, g_m);
        chk("env_done_quiet", rsp_done, 0);
      end else if (busy_m && !sent_m) begin
        if (ready_prev) begin
          sent_m = 1; m_out = 1;
          m_dly = $urandom_range(0, 5);
          chk("env_start_drop", write_start, 0);
        end else begin
          chk("env_start_hold", write_start, 1);
          chk("env_addr_hold", write_addr, ga_m);
        end
        chk("env_done_quiet", rsp_done, 0);
      end else if (busy_m) begin
        if (done_prev) begin
          eerr = err_prev ? onehot(g_m) : '0;
          chk("env_rsp_done", rsp_done, onehot(g_m));
          chk("env_rsp_error", rsp_error, eerr);
          busy_m = 0;
          owned  = owned & ~onehot(g_m);
          rr_m   = (g_m + 1) % N;
        end else begin
          chk("env_done_quiet", rsp_done, 0);
        end
      end else begin
        chk("env_done_quiet", rsp_done, 0);
      end
      chk("env_busy", busy, busy_m);
      chk("env_timeout", timeout, 0);
      write_done = 0;
      write_error = 0;
      if (m_out) begin
        if (m_dly == 0) begin
          write_done = 1;
          write_error = 1'($urandom_range(0, 1));
          m_out = 0;
        end else begin
          m_dly--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        write_done = 1;
        write_error = 1'($urandom_range(0, 1));
      end
      write_ready = ($urandom_range(0, 9) < 6);
      if (busy_m && !sent_m) begin
        if (stall >= 3) write_ready = 1;
        if (!write_ready) stall++;
      end
      for (int i = 0; i < N; i++) begin
        if (((pend_v | owned) & onehot(i)) == '0 &&
            (all_mode || $urandom_range(0, 3) == 0)) begin
          pend_v = pend_v | onehot(i);
          pend_addr[i] = $urandom;
          pend_data[i] = $urandom;
        end
      end
      pack();
      #1;
      ev = '0;
      w  = pick(pend_v, rr_m);
      if (!busy_m && write_ready && w >= 0) ev = onehot(w);
      chk("env_req_ready", req_ready, ev);
      acc_m = (ev != '0);
      if (acc_m) begin
        g_m  = w;
        ga_m = pend_addr[w];
        gd_m = pend_data[w];
      end
      ready_prev = write_ready;
      done_prev  = write_done;
      err_prev   = write_error;
    end
  endtask

  initial begin
    int   n;
    vec_t v;
    rst_n = 1'b0;
    req_addr = '0;
    req_data = '0;
    tbl[0] = '{4'b0100, 1'b0, 0, 0, 32'h4,        32'hF2,       2};
    tbl[1] = '{4'b0011, 1'b0, 0, 2, 32'h1000_0010, 32'hA5A5_0001, 0};
    tbl[2] = '{4'b1111, 1'b1, 5, 1, 32'h2000_0020, 32'h5A5A_0002, 1};
    tbl[3] = '{4'b1001, 1'b0, 1, 1, 32'h3000_0030, 32'hDEAD_0003, 3};
    tbl[4] = '{4'b1000, 1'b0, 0, 3, 32'h4000_0040, 32'hBEEF_0004, 3};
    tbl[5] = '{4'b0110, 1'b1, 2, 0, 32'h5000_0050, 32'hCAFE_0005, 1};
    tbl[6] = '{4'b0001, 1'b0, 0, 1, 32'h6000_0060, 32'hF00D_0006, 0};
    tbl[7] = '{4'b1101, 1'b0, 1, 0, 32'h7000_0070, 32'h1234_0007, 2};

    do_reset(32);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_done", rsp_done, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_write_start", write_start, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout", timeout, 0);

    write_done = 1;
    write_error = 1;
    @(negedge clk);
    write_done = 0;
    write_error = 0;
    chk("idle_done_ignored", rsp_done, 0);
    chk("idle_done_busy", busy, 0);

    for (int i = 0; i < 8; i++) txn(tbl[i], $sformatf("tbl%0d", i));

    do_reset(4);
    grants.delete();
    run_env(150, 1'b1);
    chk("fair_count", 64'(grants.size() >= 8), 1);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk($sformatf("fair_order%0d", i), grants[i], i % N);

    do_reset(4);
    run_env(3000, 1'b0);

    do_reset(4);
    v = '{4'b0010, 1'b0, 0, 0, 32'h11, 32'h22, 1};
    txn(v, "mid_pre");
    @(negedge clk);
    pend_v = 4'b0100;
    pend_addr[2] = 32'h33;
    pend_data[2] = 32'h44;
    pack();
    write_ready = 1;
    @(negedge clk);
    pend_v = '0;
    pack();
    @(negedge clk);
    write_ready = 0;
    chk("mid_in_wait", {busy, write_start}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", write_addr, 0);
    chk("mid_rst_grant", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    write_done = 1;
    @(negedge clk);
    write_done = 0;
    chk("mid_late_done", rsp_done, 0);
    chk("mid_late_busy", busy, 0);
    pend_v = 4'b1111;
    pack();
    write_ready = 1;
    #1;
    chk("mid_rr_reset", req_ready, 4'b0001);

    do_reset(4);
    pend_v = 4'b0010;
    pack();
    write_ready = 1;
    #1;
    chk("to_req_ready", req_ready, 4'b0010);
    @(negedge clk);
    pend_v = '0;
    pack();
    write_ready = 0;
`ifdef AXI4_WR_ARB_TIMEOUT_EN
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_done != '0) break;
    end
    chk("to_cycles", n, TO);
    chk("to_rsp_done", rsp_done, 4'b0010);
    chk("to_rsp_error", rsp_error, 4'b0010);
    chk("to_flag", timeout, 1);
    chk("to_start_drop", write_start, 0);
    chk("to_busy", busy, 0);
    pend_v = 4'b1111;
    pack();
    write_ready = 1;
    #1;
    chk("to_next_grant", req_ready, 4'b0100);
    @(negedge clk);
    pend_v = '0;
    pack();
    @(negedge clk);
    chk("to_sticky", timeout, 1);
`else
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_done != '0) n++;
    end
    chk("nto_no_done", n, 0);
    chk("nto_busy", busy, 1);
    chk("nto_start", write_start, 1);
    chk("nto_flag", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_write_arbiter.md
# axi4_write_arbiter

Round-robin arbiter that shares the single-beat write command port of `axi4_master` (WRITE_START/ADDR/DATA, WRITE_READY/DONE/ERROR) between P_NUM_REQ requesters. It sits between the requester logic and `axi4_master` inside the block design. It keeps at most one write outstanding, routes completion and error status back to the granted requester, and can optionally abort a write that never completes.

## Interface
Parameters:
- P_NUM_REQ, 4, number of requesters (2..16)
- P_ADDR_WIDTH, 32, write address width
- P_DATA_WIDTH, 32, write data width
- P_TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the timeout macro)

Ports:
- CLOCK  in  1  single clock; all logic on the rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ_VALID  in  P_NUM_REQ  per-requester write request
- REQ_ADDR  in  P_NUM_REQ*P_ADDR_WIDTH  packed addresses; requester i at [i*P_ADDR_WIDTH +: P_ADDR_WIDTH]
- REQ_DATA  in  P_NUM_REQ*P_DATA_WIDTH  packed data, same packing
- REQ_READY  out  P_NUM_REQ  accept strobe, combinational, one-hot or zero
- RSP_DONE  out  P_NUM_REQ  one-cycle completion pulse to the owning requester
- RSP_ERROR  out  P_NUM_REQ  valid only with RSP_DONE; 1 means failed write
- WRITE_START  out  1  command valid toward `axi4_master`
- WRITE_ADDR  out  P_ADDR_WIDTH  latched address
- WRITE_DATA  out  P_DATA_WIDTH  latched data
- WRITE_READY  in  1  master can accept a command
- WRITE_DONE  in  1  master completion pulse
- WRITE_ERROR  in  1  master error; sampled only with WRITE_DONE
- BUSY  out  1  high whenever state is not IDLE
- GRANT_ID  out  $clog2(P_NUM_REQ)  index of the current or last grant
- TIMEOUT  out  1  sticky watchdog flag; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- Round-robin pointer `rr` is reset to 0. The winner is the first i with REQ_VALID[i]=1, searching from rr upward and wrapping modulo P_NUM_REQ.
- **IDLE**
  - REQ_READY[winner]=1 only when WRITE_READY=1 and at least one REQ_VALID is high.
  - A request is accepted on an edge where REQ_VALID[i] and REQ_READY[i] are both high.
  - On accept: latch REQ_ADDR[i] and REQ_DATA[i] into WRITE_ADDR/WRITE_DATA, set GRANT_ID=i, go to ISSUE.
- **ISSUE**
  - WRITE_START=1, with address and data held stable.
  - On an edge with WRITE_READY=1: WRITE_START drops and the state goes to WAIT.
- **WAIT**
  - On an edge with WRITE_DONE=1: RSP_DONE[GRANT_ID]=1 and RSP_ERROR[GRANT_ID]=WRITE_ERROR for the next cycle.
  - Also on that edge: rr=(GRANT_ID+1) mod P_NUM_REQ, state goes to IDLE.
- WRITE_DONE seen in IDLE or ISSUE is ignored.
- Requesters must hold REQ_VALID, REQ_ADDR and REQ_DATA stable until accepted. A requester must not re-request until its RSP_DONE pulse.
- While not in IDLE, REQ_READY is all zero. Lower-priority requesters wait; nothing is dropped.
- Reset values: REQ_READY=0, RSP_DONE=0, RSP_ERROR=0, WRITE_START=0, WRITE_ADDR=0, WRITE_DATA=0, BUSY=0, GRANT_ID=0, TIMEOUT=0, state=IDLE, rr=0.
- Reset mid-operation: the in-flight write is abandoned with no RSP_DONE. A late WRITE_DONE after reset is ignored.

## Timing
- Accept at edge k. WRITE_START is high from cycle k+1 until the edge where WRITE_READY is sampled high (at least 1 cycle).
- WRITE_DONE at edge m: RSP_DONE pulses in cycle m+1. A new request can be accepted at edge m+1, so the gap between commands is at least 1 cycle.
- RSP_DONE is exactly one cycle wide and never asserts for two requesters in the same cycle.
- REQ_READY is the only combinational output. All other outputs are registered.

## Configuration
- Macro: `AXI4_WR_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in ISSUE and WAIT and clears on entry to ISSUE.
  - When it reaches P_TIMEOUT_CYCLES with no WRITE_DONE: RSP_DONE[GRANT_ID]=1, RSP_ERROR[GRANT_ID]=1, TIMEOUT is set, rr advances, state goes to IDLE.
  - WRITE_START deasserts on the timeout edge.
- Not defined: no counter is built, TIMEOUT is tied to 0, and WAIT lasts indefinitely.

## Test plan
- **Reset values:** hold RESET=0 for 32 cycles, then release → all outputs at their reset values; BUSY=0.
- **Single request:** REQ_VALID[2]=1, addr 0x04, data 0xF2, WRITE_READY=1 → REQ_READY[2] pulses; WRITE_START, WRITE_ADDR=0x04 and WRITE_DATA=0xF2 appear the next cycle; WRITE_DONE returns → RSP_DONE[2]=1 and RSP_ERROR[2]=0 for one cycle; GRANT_ID=2.
- **Round-robin fairness:** all four requesters valid continuously → grant order 0,1,2,3,0; each requester gets exactly one RSP_DONE per round.
- **Error return and back-pressure:** WRITE_READY held low for 5 cycles in ISSUE → WRITE_START stays high for 5+ cycles with address and data stable. WRITE_DONE with WRITE_ERROR=1 → RSP_ERROR[g]=1; other requesters see no RSP_DONE.
- **Reset mid-operation:** assert RESET in WAIT, then pulse WRITE_DONE after release → no RSP_DONE; state IDLE; rr=0.
- **Timeout (macro defined, P_TIMEOUT_CYCLES=16):** grant requester 1 and never return WRITE_DONE → 16 cycles after entering ISSUE, RSP_DONE[1]=1, RSP_ERROR[1]=1 and TIMEOUT=1 (sticky); the next grant goes to requester 2.
